// File: rtl/axis_detector_arbiter.sv
// axis_detector_arbiter
//   Merges NUM_PORTS detector reader streams (tvalid only, no backpressure)
//   into one AXI4-Stream master. Each port feeds a FIFO_DEPTH-entry FIFO.
//   The FIFOs are drained into a registered output stage that honours
//   m_axis_tready. A port that strobes into a full FIFO loses the event,
//   and the loss is counted in sts_data.
//
//   Build option: define AXIS_DETECTOR_ARBITER_PRIORITY_EN to use fixed
//   priority (lowest index wins) in place of round-robin.
//
// Ports
//   aclk, aresetn          clock, synchronous active-low reset
//   cfg_data[P]            per-port enable mask
//   s_axis_tdata/tvalid    reader inputs, port i at tdata[i*W +: W]
//   m_axis_tdata/tid/tvalid/tready  merged output stream (tid = source port)
//   sts_data[32]           saturating count of dropped events

module axis_detector_arbiter_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 4
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  // The extra MSB tells full from empty when the index bits match.
  logic [AW:0]  wr_ptr, rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

module axis_detector_arbiter #(
  parameter int NUM_PORTS        = 4,
  parameter int AXIS_TDATA_WIDTH = 128,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                                  aclk,
  input  logic                                  aresetn,
  input  logic [NUM_PORTS-1:0]                  cfg_data,
  input  logic [NUM_PORTS*AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]                  s_axis_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0]           m_axis_tdata,
  output logic [$clog2(NUM_PORTS)-1:0]          m_axis_tid,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic [31:0]                           sts_data
);
  localparam int W   = AXIS_TDATA_WIDTH;
  localparam int IDW = $clog2(NUM_PORTS);
  localparam int CW  = $clog2(NUM_PORTS + 1);

  logic [NUM_PORTS-1:0]        empty, full, wr_en, pop, drop;
  logic [NUM_PORTS-1:0][W-1:0] head;
  logic                        loadable, gnt_vld, load;
  logic [IDW-1:0]              gnt_idx;
  logic [CW-1:0]               drop_cnt;
  logic [32:0]                 sts_sum;

  assign loadable = ~m_axis_tvalid | m_axis_tready;
  assign load     = loadable & gnt_vld;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    // A full FIFO still takes the write when it is popped in the same cycle.
    assign pop[i]   = load & (gnt_idx == IDW'(i));
    assign wr_en[i] = s_axis_tvalid[i] & cfg_data[i] & (~full[i] | pop[i]);
    assign drop[i]  = s_axis_tvalid[i] & cfg_data[i] & full[i] & ~pop[i];

    axis_detector_arbiter_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .aclk    (aclk),
      .aresetn (aresetn),
      .wr_en   (wr_en[i]),
      .wr_data (s_axis_tdata[i*W +: W]),
      .rd_en   (pop[i]),
      .rd_data (head[i]),
      .empty   (empty[i]),
      .full    (full[i])
    );
  end

`ifdef AXIS_DETECTOR_ARBITER_PRIORITY_EN
  // Descending scan so the lowest non-empty index is the last one written.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (!empty[k]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDW'(k);
      end
    end
  end
`else
  logic [IDW-1:0] rr_ptr;

  // Descending distance from rr_ptr so the nearest port after it wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!empty[IDW'(idx)]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn)  rr_ptr <= IDW'(NUM_PORTS - 1);
    else if (load) rr_ptr <= gnt_idx;
  end
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tid    <= '0;
    end else if (loadable) begin
      m_axis_tvalid <= gnt_vld;
      if (gnt_vld) begin
        m_axis_tdata <= head[gnt_idx];
        m_axis_tid   <= gnt_idx;
      end
    end
  end

  // All drops of one cycle are added in a single saturating step.
  always_comb begin
    drop_cnt = '0;
    for (int i = 0; i < NUM_PORTS; i++) drop_cnt = drop_cnt + CW'(drop[i]);
  end

  assign sts_sum = {1'b0, sts_data} + 33'(drop_cnt);

  always_ff @(posedge aclk) begin
    if (!aresetn) sts_data <= '0;
    else          sts_data <= sts_sum[32] ? 32'hFFFF_FFFF : sts_sum[31:0];
  end
endmodule

// File: tb/tb_axis_detector_arbiter.sv
// Self-checking bench for axis_detector_arbiter (NUM_PORTS=4, W=128, DEPTH=4).
// Expected beats are queued as stimulus is driven. A negedge monitor records
// every output handshake, and each test compares the two queues.
module tb_axis_detector_arbiter;
  localparam int N   = 4;
  localparam int W   = 128;
  localparam int IDW = 2;

  typedef struct packed {
    logic [IDW-1:0] tid;
    logic [W-1:0]   data;
  } beat_t;

  logic                 aclk = 1'b0;
  logic                 aresetn = 1'b0;
  logic [N-1:0]         cfg_data = '1;
  logic [N-1:0][W-1:0]  s_tdata = '0;
  logic [N-1:0]         s_tvalid = '0;
  logic [W-1:0]         m_axis_tdata;
  logic [IDW-1:0]       m_axis_tid;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready = 1'b1;
  logic [31:0]          sts_data;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    obs_cyc[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_err = 0;

  axis_detector_arbiter #(.NUM_PORTS(N), .AXIS_TDATA_WIDTH(W), .FIFO_DEPTH(4)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_data      (cfg_data),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tid    (m_axis_tid),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .sts_data      (sts_data)
  );

  initial forever #5 aclk = ~aclk;

  always @(posedge aclk) cyc++;

  always @(negedge aclk) begin
    beat_t b;
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      b.tid  = m_axis_tid;
      b.data = m_axis_tdata;
      obs_q.push_back(b);
      obs_cyc.push_back(cyc);
    end
  end

  function automatic logic [W-1:0] mk(input int p, input int s);
    return {32'(p), 32'(s), 32'hC0DE_0000, 32'(p * 1000 + s)};
  endfunction

  function automatic beat_t bt(input int p, input logic [W-1:0] d);
    beat_t b;
    b.tid  = IDW'(p);
    b.data = d;
    return b;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0][W-1:0] d);
    s_tvalid = v;
    s_tdata  = d;
    tick();
    s_tvalid = '0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    s_tvalid = '0;
    cfg_data = '1;
    m_axis_tready = 1'b1;
    repeat (2) tick();
    aresetn = 1'b1;
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic wait_drain(input int budget);
    for (int c = 0; c < budget && obs_q.size() < exp_q.size(); c++) tick();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tid !== '0 || sts_data !== '0) begin
      n_err++;
      $display("FAIL reset_state: got tvalid=%b tid=%0d data=%h sts=%0d, want all zero",
               m_axis_tvalid, m_axis_tid, m_axis_tdata, sts_data);
    end
    aresetn = 1'b1;
  endtask

  task automatic test_single();
    logic [N-1:0][W-1:0] d = '0;
    beat_t e, o;
    do_reset();
    d[2] = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_0001;
    exp_q.push_back(bt(2, d[2]));
    drive(4'b0100, d);
    @(negedge aclk);
    n_cmp++;
    if (m_axis_tvalid !== 1'b0) begin
      n_err++; $display("FAIL single_early: tvalid got %b want 0", m_axis_tvalid);
    end
    tick();
    @(negedge aclk);
    n_cmp++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tid !== 2'd2 || m_axis_tdata !== d[2]) begin
      n_err++;
      $display("FAIL single_latency: got tvalid=%b tid=%0d data=%h want 1/2/%h",
               m_axis_tvalid, m_axis_tid, m_axis_tdata, d[2]);
    end
    tick();
    @(negedge aclk);
    n_cmp++;
    if (m_axis_tvalid !== 1'b0) begin
      n_err++; $display("FAIL single_one_cycle: tvalid got %b want 0", m_axis_tvalid);
    end
    wait_drain(10);
    n_cmp++;
    if (obs_q.size() != exp_q.size() || sts_data !== 32'd0) begin
      n_err++;
      $display("FAIL single_count: got %0d beats sts=%0d want %0d beats sts=0",
               obs_q.size(), sts_data, exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++; $display("FAIL single_beat: got tid=%0d %h want tid=%0d %h", o.tid, o.data, e.tid, e.data);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0][W-1:0] d;
    beat_t e, o;
    do_reset();
    for (int b = 0; b < 2; b++) begin
      for (int p = 0; p < N; p++) begin
        d[p] = mk(p, b);
        exp_q.push_back(bt(p, d[p]));
      end
      drive(4'b1111, d);
      wait_drain(20);
    end
    n_cmp++;
    if (obs_cyc.size() < 4 || obs_cyc[3] - obs_cyc[0] != 3) begin
      n_err++;
      $display("FAIL rr_back_to_back: got %0d beats, span %0d cycles, want 4 beats span 3",
               obs_cyc.size(), (obs_cyc.size() >= 4) ? obs_cyc[3] - obs_cyc[0] : -1);
    end
    d = '0;
    d[1] = mk(1, 2);
    d[3] = mk(3, 2);
    exp_q.push_back(bt(1, d[1]));
    exp_q.push_back(bt(3, d[3]));
    drive(4'b1010, d);
    wait_drain(20);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rr_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++; $display("FAIL rr_beat: got tid=%0d %h want tid=%0d %h", o.tid, o.data, e.tid, e.data);
      end
    end
  endtask

  task automatic test_overflow();
    logic [N-1:0][W-1:0] d = '0;
    beat_t e, o;
    do_reset();
    m_axis_tready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      d[1] = mk(1, k);
      if (k <= 5) exp_q.push_back(bt(1, d[1]));
      drive(4'b0010, d);
    end
    n_cmp++;
    if (sts_data !== 32'd1) begin
      n_err++; $display("FAIL ovf_drop_count: sts got %0d want 1", sts_data);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      n_cmp++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tid !== 2'd1 || m_axis_tdata !== mk(1, 1)) begin
        n_err++;
        $display("FAIL ovf_stall_hold: got tvalid=%b tid=%0d %h want 1/1/%h",
                 m_axis_tvalid, m_axis_tid, m_axis_tdata, mk(1, 1));
      end
      tick();
    end
    m_axis_tready = 1'b1;
    wait_drain(20);
    n_cmp++;
    if (obs_q.size() != exp_q.size() || sts_data !== 32'd1) begin
      n_err++;
      $display("FAIL ovf_count: got %0d beats sts=%0d want %0d beats sts=1",
               obs_q.size(), sts_data, exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++; $display("FAIL ovf_beat: got tid=%0d %h want tid=%0d %h", o.tid, o.data, e.tid, e.data);
      end
    end
  endtask

  task automatic test_full_pop();
    logic [N-1:0][W-1:0] d = '0;
    beat_t e, o;
    do_reset();
    m_axis_tready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      d[1] = mk(1, k);
      exp_q.push_back(bt(1, d[1]));
      drive(4'b0010, d);
    end
    m_axis_tready = 1'b1;
    d[1] = mk(1, 6);
    exp_q.push_back(bt(1, d[1]));
    drive(4'b0010, d);
    n_cmp++;
    if (sts_data !== 32'd0) begin
      n_err++; $display("FAIL fullpop_no_drop: sts got %0d want 0", sts_data);
    end
    wait_drain(20);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL fullpop_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++; $display("FAIL fullpop_beat: got tid=%0d %h want tid=%0d %h", o.tid, o.data, e.tid, e.data);
      end
    end
  endtask

  task automatic test_multi_drop();
    logic [N-1:0][W-1:0] d = '0;
    do_reset();
    m_axis_tready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      d[1] = mk(1, k);
      d[2] = mk(2, k);
      drive(4'b0110, d);
    end
    n_cmp++;
    if (sts_data !== 32'd3) begin
      n_err++; $display("FAIL multi_drop: sts got %0d want 3", sts_data);
    end
  endtask

  task automatic test_mask_reset();
    logic [N-1:0][W-1:0] d = '0;
    beat_t e, o;
    do_reset();
    cfg_data = 4'b0001;
    d[0] = mk(0, 7);
    d[3] = mk(3, 7);
    exp_q.push_back(bt(0, d[0]));
    drive(4'b1001, d);
    wait_drain(20);
    n_cmp++;
    if (obs_q.size() != exp_q.size() || sts_data !== 32'd0) begin
      n_err++;
      $display("FAIL mask_count: got %0d beats sts=%0d want %0d beats sts=0",
               obs_q.size(), sts_data, exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++; $display("FAIL mask_beat: got tid=%0d %h want tid=%0d %h", o.tid, o.data, e.tid, e.data);
      end
    end
    cfg_data = 4'b1111;
    m_axis_tready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      d = '0;
      d[2] = mk(2, k);
      drive(4'b0100, d);
    end
    n_cmp++;
    if (sts_data !== 32'd1) begin
      n_err++; $display("FAIL mask_pre_reset_sts: sts got %0d want 1", sts_data);
    end
    aresetn = 1'b0;
    tick();
    @(negedge aclk);
    n_cmp++;
    if (m_axis_tvalid !== 1'b0 || sts_data !== 32'd0) begin
      n_err++;
      $display("FAIL midrun_reset: got tvalid=%b sts=%0d want 0/0", m_axis_tvalid, sts_data);
    end
    aresetn = 1'b1;
    m_axis_tready = 1'b1;
    repeat (10) tick();
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_err++; $display("FAIL midrun_reset_flush: got %0d beats after reset want 0", obs_q.size());
    end
  endtask

  task automatic test_arbitration();
    logic [N-1:0][W-1:0] d = '0;
    beat_t e, o;
    do_reset();
    d[1] = mk(1, 0);
`ifdef AXIS_DETECTOR_ARBITER_PRIORITY_EN
    for (int k = 0; k < 8; k++) exp_q.push_back(bt(0, mk(0, k)));
    exp_q.push_back(bt(1, mk(1, 0)));
`else
    exp_q.push_back(bt(0, mk(0, 0)));
    exp_q.push_back(bt(1, mk(1, 0)));
    for (int k = 1; k < 8; k++) exp_q.push_back(bt(0, mk(0, k)));
`endif
    for (int k = 0; k < 8; k++) begin
      d[0] = mk(0, k);
      drive((k == 0) ? 4'b0011 : 4'b0001, d);
    end
    wait_drain(30);
    n_cmp++;
    if (obs_q.size() != exp_q.size() || obs_cyc.size() < 9 || obs_cyc[8] - obs_cyc[0] != 8) begin
      n_err++;
      $display("FAIL arb_count: got %0d beats want %0d back-to-back", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++; $display("FAIL arb_beat: got tid=%0d %h want tid=%0d %h", o.tid, o.data, e.tid, e.data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_full_pop();
    test_multi_drop();
    test_mask_reset();
    test_arbitration();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end
endmodule
